control_sequencer: RTL and testbench

- Microcoded control sequencer for the 8-bit computer datapath.
- Decodes the instruction register opcode into per-step control strobes and a bus-source select.
- Adds several capabilities to the base controller:
  - conditional jumps JC and JZ on carry_flag / zero_flag;
  - flags_in capture on ADD and SUB;
  - a latched halt;
  - a parametrised opcode width;
  - a selectable fixed-length or variable-length instruction cycle.
- Sits between the instruction register / flags register and every datapath load/enable.

---
 rtl/control_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcoded control sequencer for the 8-bit computer datapath
//
// Decodes the instruction register opcode, one microstep per falling clock
// edge, into datapath load/enable strobes and a bus-source select. Every
// output is registered, so it holds for a full clock period after the edge.
//
// Ports:
//   clock          system clock, all state changes on the falling edge
//   bReset         asynchronous active-low reset
//   instruction    opcode from the instruction register (low 4 bits decoded)
//   carry_flag     latched carry, sampled on the step-2 edge of JC
//   zero_flag      latched zero, sampled on the step-2 edge of JZ
//   hlt            clock-halt request, sticky until reset
//   memory_in      MAR load
//   ram_in         RAM write
//   instruction_in IR load
//   reg_a_in       A load
//   subtract       ALU subtract mode
//   reg_b_in       B load
//   out_in         output register load
//   advance_pc     PC increment
//   pc_in          PC load
//   flags_in       flags register load
//   bus_selector   bus source (0 none, 1 PC, 2 memory, 3 IR, 4 A, 5 ALU)
//   step           current microstep, for debug/trace

module control_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter bit FIXED_LEN = 1'b0,
  parameter int BUS_SEL_W = 3
) (
  input  logic                 clock,
  input  logic                 bReset,
  input  logic [OPCODE_W-1:0]  instruction,
  input  logic                 carry_flag,
  input  logic                 zero_flag,
  output logic                 hlt,
  output logic                 memory_in,
  output logic                 ram_in,
  output logic                 instruction_in,
  output logic                 reg_a_in,
  output logic                 subtract,
  output logic                 reg_b_in,
  output logic                 out_in,
  output logic                 advance_pc,
  output logic                 pc_in,
  output logic                 flags_in,
  output logic [BUS_SEL_W-1:0] bus_selector,
  output logic [2:0]           step
);

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_EXEC2  = 3'd2,
    ST_EXEC3  = 3'd3,
    ST_EXEC4  = 3'd4
  } step_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [BUS_SEL_W-1:0] BUS_NONE = BUS_SEL_W'(0);
  localparam logic [BUS_SEL_W-1:0] BUS_PC   = BUS_SEL_W'(1);
  localparam logic [BUS_SEL_W-1:0] BUS_MEM  = BUS_SEL_W'(2);
  localparam logic [BUS_SEL_W-1:0] BUS_IR   = BUS_SEL_W'(3);
  localparam logic [BUS_SEL_W-1:0] BUS_REGA = BUS_SEL_W'(4);
  localparam logic [BUS_SEL_W-1:0] BUS_ALU  = BUS_SEL_W'(5);

  step_t cur_step, nxt_step;
  logic  halted, nxt_halted;
  logic  last;

  logic n_hlt, n_memory_in, n_ram_in, n_instruction_in, n_reg_a_in;
  logic n_subtract, n_reg_b_in, n_out_in, n_advance_pc, n_pc_in, n_flags_in;
  logic [BUS_SEL_W-1:0] n_bus;

  // Any set bit above the low nibble turns the opcode into a NOP.
  logic       op_hi_nz;
  logic [3:0] op;

  generate
    if (OPCODE_W > 4) begin : g_wide_op
      assign op_hi_nz = |instruction[OPCODE_W-1:4];
    end else begin : g_narrow_op
      assign op_hi_nz = 1'b0;
    end
  endgenerate

  assign op   = op_hi_nz ? OP_NOP : instruction[3:0];
  assign step = cur_step;

  always_comb begin
    n_hlt            = 1'b0;
    n_memory_in      = 1'b0;
    n_ram_in         = 1'b0;
    n_instruction_in = 1'b0;
    n_reg_a_in       = 1'b0;
    n_subtract       = 1'b0;
    n_reg_b_in       = 1'b0;
    n_out_in         = 1'b0;
    n_advance_pc     = 1'b0;
    n_pc_in          = 1'b0;
    n_flags_in       = 1'b0;
    n_bus            = BUS_NONE;
    nxt_step         = step_t'(cur_step + 3'd1);
    nxt_halted       = halted;
    last             = 1'b0;

    if (halted) begin
      // Frozen: only the halt request stays up, step does not move.
      n_hlt    = 1'b1;
      nxt_step = cur_step;
    end else begin
      case (cur_step)
        ST_FETCH0: begin
          n_bus       = BUS_PC;
          n_memory_in = 1'b1;
        end
        ST_FETCH1: begin
          n_bus            = BUS_MEM;
          n_instruction_in = 1'b1;
          n_advance_pc     = 1'b1;
        end
        ST_EXEC2: begin
          case (op)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              n_bus       = BUS_IR;
              n_memory_in = 1'b1;
            end
            OP_LDI: begin
              n_bus      = BUS_IR;
              n_reg_a_in = 1'b1;
              last       = 1'b1;
            end
            OP_JMP: begin
              n_bus   = BUS_IR;
              n_pc_in = 1'b1;
              last    = 1'b1;
            end
            OP_JC: begin
              n_bus   = carry_flag ? BUS_IR : BUS_NONE;
              n_pc_in = carry_flag;
              last    = 1'b1;
            end
            OP_JZ: begin
              n_bus   = zero_flag ? BUS_IR : BUS_NONE;
              n_pc_in = zero_flag;
              last    = 1'b1;
            end
            OP_OUT: begin
              n_bus    = BUS_REGA;
              n_out_in = 1'b1;
              last     = 1'b1;
            end
            OP_HLT: begin
              // Not an end step: step moves on to 3 and then freezes there.
              n_hlt      = 1'b1;
              nxt_halted = 1'b1;
            end
            default: last = 1'b1;
          endcase
        end
        ST_EXEC3: begin
          case (op)
            OP_LDA: begin
              n_bus      = BUS_MEM;
              n_reg_a_in = 1'b1;
              last       = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              n_bus      = BUS_MEM;
              n_reg_b_in = 1'b1;
            end
            OP_STA: begin
              n_bus    = BUS_REGA;
              n_ram_in = 1'b1;
              last     = 1'b1;
            end
            // Idle padding step, or the opcode changed under us: finish.
            default: last = 1'b1;
          endcase
        end
        ST_EXEC4: begin
          if (op == OP_ADD || op == OP_SUB) begin
            n_bus      = BUS_ALU;
            n_reg_a_in = 1'b1;
            n_flags_in = 1'b1;
            n_subtract = (op == OP_SUB);
          end
          last = 1'b1;
        end
        // Steps 5..7 are unreachable; recover to fetch with idle outputs.
        default: nxt_step = ST_FETCH0;
      endcase

      // Fixed-length cycles pad with idle steps and only wrap after step 4.
      if (last && (!FIXED_LEN || cur_step == ST_EXEC4)) begin
        nxt_step = ST_FETCH0;
      end
    end
  end

  always_ff @(negedge clock or negedge bReset) begin
    if (!bReset) begin
      cur_step       <= ST_FETCH0;
      halted         <= 1'b0;
      hlt            <= 1'b0;
      memory_in      <= 1'b0;
      ram_in         <= 1'b0;
      instruction_in <= 1'b0;
      reg_a_in       <= 1'b0;
      subtract       <= 1'b0;
      reg_b_in       <= 1'b0;
      out_in         <= 1'b0;
      advance_pc     <= 1'b0;
      pc_in          <= 1'b0;
      flags_in       <= 1'b0;
      bus_selector   <= BUS_NONE;
    end else begin
      cur_step       <= nxt_step;
      halted         <= nxt_halted;
      hlt            <= n_hlt;
      memory_in      <= n_memory_in;
      ram_in         <= n_ram_in;
      instruction_in <= n_instruction_in;
      reg_a_in       <= n_reg_a_in;
      subtract       <= n_subtract;
      reg_b_in       <= n_reg_b_in;
      out_in         <= n_out_in;
      advance_pc     <= n_advance_pc;
      pc_in          <= n_pc_in;
      flags_in       <= n_flags_in;
      bus_selector   <= n_bus;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer (variable and fixed length)

module tb_control_sequencer;

  // Control word bit masks, hlt down to flags_in.
  localparam logic [10:0] C_HLT = 11'h400;
  localparam logic [10:0] C_MI  = 11'h200;
  localparam logic [10:0] C_RI  = 11'h100;
  localparam logic [10:0] C_II  = 11'h080;
  localparam logic [10:0] C_RAI = 11'h040;
  localparam logic [10:0] C_SUB = 11'h020;
  localparam logic [10:0] C_RBI = 11'h010;
  localparam logic [10:0] C_OI  = 11'h008;
  localparam logic [10:0] C_APC = 11'h004;
  localparam logic [10:0] C_PCI = 11'h002;
  localparam logic [10:0] C_FI  = 11'h001;

  localparam logic [2:0] B_NONE = 3'd0;
  localparam logic [2:0] B_PC   = 3'd1;
  localparam logic [2:0] B_MEM  = 3'd2;
  localparam logic [2:0] B_IR   = 3'd3;
  localparam logic [2:0] B_A    = 3'd4;
  localparam logic [2:0] B_ALU  = 3'd5;

  logic clock = 1'b0;
  initial forever #5 clock = ~clock;

  logic       rst0, rst1;
  logic [3:0] instr0;
  logic [4:0] instr1;
  logic       c0, z0, c1, z1;

  logic hlt0, mi0, ri0, ii0, rai0, sub0, rbi0, oi0, apc0, pci0, fi0;
  logic hlt1, mi1, ri1, ii1, rai1, sub1, rbi1, oi1, apc1, pci1, fi1;
  logic [2:0] bus0, bus1, step0, step1;
  logic [16:0] obs0, obs1;

  assign obs0 = {hlt0, mi0, ri0, ii0, rai0, sub0, rbi0, oi0, apc0, pci0, fi0, bus0, step0};
  assign obs1 = {hlt1, mi1, ri1, ii1, rai1, sub1, rbi1, oi1, apc1, pci1, fi1, bus1, step1};

  control_sequencer #(.OPCODE_W(4), .FIXED_LEN(1'b0), .BUS_SEL_W(3)) dut_var (
    .clock(clock), .bReset(rst0), .instruction(instr0),
    .carry_flag(c0), .zero_flag(z0),
    .hlt(hlt0), .memory_in(mi0), .ram_in(ri0), .instruction_in(ii0),
    .reg_a_in(rai0), .subtract(sub0), .reg_b_in(rbi0), .out_in(oi0),
    .advance_pc(apc0), .pc_in(pci0), .flags_in(fi0),
    .bus_selector(bus0), .step(step0)
  );

  control_sequencer #(.OPCODE_W(5), .FIXED_LEN(1'b1), .BUS_SEL_W(3)) dut_fix (
    .clock(clock), .bReset(rst1), .instruction(instr1),
    .carry_flag(c1), .zero_flag(z1),
    .hlt(hlt1), .memory_in(mi1), .ram_in(ri1), .instruction_in(ii1),
    .reg_a_in(rai1), .subtract(sub1), .reg_b_in(rbi1), .out_in(oi1),
    .advance_pc(apc1), .pc_in(pci1), .flags_in(fi1),
    .bus_selector(bus1), .step(step1)
  );

  logic [16:0] q0[$];
  logic [16:0] q1[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%05h want=%05h", name, $time, got, want);
    end
  endtask

  // Monitor: every falling edge yields one output word, read half a period later.
  initial begin
    logic [16:0] w;
    forever begin
      @(posedge clock);
      if (q0.size() > 0) begin
        w = q0.pop_front();
        check("var_edge", obs0, w);
      end
      if (q1.size() > 0) begin
        w = q1.pop_front();
        check("fix_edge", obs1, w);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got=timeout want=finish");
    $fatal(1);
  end

  task automatic do_edge(input int d, input logic [16:0] want);
    if (d == 0) q0.push_back(want);
    else        q1.push_back(want);
    @(negedge clock);
    @(posedge clock);
    #2;
  endtask

  task automatic set_in(input int d, input logic [4:0] op, input logic c, input logic z);
    if (d == 0) begin
      instr0 = op[3:0]; c0 = c; z0 = z;
    end else begin
      instr1 = op; c1 = c; z1 = z;
    end
  endtask

  // Reference: microprogram list per opcode; step after edge i is (i+1) mod length.
  task automatic run_instr(input int d, input logic [4:0] op, input logic c, input logic z,
                           input int stop_after);
    logic [13:0] prog[$];
    logic [3:0]  lo;
    int n, lim;
    lo = op[3:0];
    if (d == 1 && op[4]) lo = 4'h0;
    prog.push_back({C_MI, B_PC});
    prog.push_back({C_II | C_APC, B_MEM});
    case (lo)
      4'h1: begin prog.push_back({C_MI, B_IR}); prog.push_back({C_RAI, B_MEM}); end
      4'h2, 4'h3: begin
        prog.push_back({C_MI, B_IR});
        prog.push_back({C_RBI, B_MEM});
        prog.push_back({C_RAI | C_FI | ((lo == 4'h3) ? C_SUB : 11'h0), B_ALU});
      end
      4'h4: begin prog.push_back({C_MI, B_IR}); prog.push_back({C_RI, B_A}); end
      4'h5: prog.push_back({C_RAI, B_IR});
      4'h6: prog.push_back({C_PCI, B_IR});
      4'h7: prog.push_back(c ? {C_PCI, B_IR} : 14'h0);
      4'h8: prog.push_back(z ? {C_PCI, B_IR} : 14'h0);
      4'hE: prog.push_back({C_OI, B_A});
      default: prog.push_back(14'h0);
    endcase
    while (d == 1 && prog.size() < 5) prog.push_back(14'h0);
    n   = prog.size();
    lim = (stop_after < 0) ? n : stop_after;
    set_in(d, op, c, z);
    for (int i = 0; i < lim; i++) do_edge(d, {prog[i], 3'((i + 1) % n)});
  endtask

  task automatic reset_pulse(input int d);
    if (d == 0) rst0 = 1'b0;
    else        rst1 = 1'b0;
    #1;
    check(d == 0 ? "var_async_reset" : "fix_async_reset", d == 0 ? obs0 : obs1, 17'h0);
    do_edge(d, 17'h0);
    if (d == 0) rst0 = 1'b1;
    else        rst1 = 1'b1;
  endtask

  initial begin
    logic [4:0] op;
    rst0 = 1'b0; rst1 = 1'b0;
    instr0 = 4'h0; instr1 = 5'h0;
    c0 = 1'b0; z0 = 1'b0; c1 = 1'b0; z1 = 1'b0;
    @(posedge clock);
    #2;
    check("var_reset_state", obs0, 17'h0);
    check("fix_reset_state", obs1, 17'h0);
    do_edge(0, 17'h0);
    rst0 = 1'b1;

    run_instr(0, 5'h01, 1'b0, 1'b0, -1);
    run_instr(0, 5'h03, 1'b0, 1'b0, -1);
    run_instr(0, 5'h02, 1'b1, 1'b1, -1);
    run_instr(0, 5'h07, 1'b1, 1'b0, -1);
    run_instr(0, 5'h07, 1'b0, 1'b1, -1);
    run_instr(0, 5'h08, 1'b0, 1'b1, -1);
    run_instr(0, 5'h08, 1'b1, 1'b0, -1);
    run_instr(0, 5'h04, 1'b0, 1'b0, -1);
    run_instr(0, 5'h0E, 1'b0, 1'b0, -1);
    run_instr(0, 5'h0B, 1'b0, 1'b0, -1);

    // Abort ADD while step 3 is held, then restart from fetch.
    run_instr(0, 5'h02, 1'b0, 1'b0, 3);
    reset_pulse(0);
    run_instr(0, 5'h06, 1'b0, 1'b0, -1);

    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 14));
      run_instr(0, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    // Halt: sticky hlt, step frozen at 3, cleared only by reset.
    set_in(0, 5'h0F, 1'b0, 1'b0);
    do_edge(0, {C_MI, B_PC, 3'd1});
    do_edge(0, {C_II | C_APC, B_MEM, 3'd2});
    do_edge(0, {C_HLT, B_NONE, 3'd3});
    for (int k = 0; k < 10; k++) do_edge(0, {C_HLT, B_NONE, 3'd3});
    reset_pulse(0);
    run_instr(0, 5'h05, 1'b0, 1'b0, -1);

    // Fixed-length instance, 5-bit opcode.
    rst0 = 1'b0;
    rst1 = 1'b1;
    run_instr(1, 5'h05, 1'b0, 1'b0, -1);
    run_instr(1, 5'h03, 1'b0, 1'b0, -1);
    run_instr(1, 5'h15, 1'b0, 1'b0, -1);
    run_instr(1, 5'h07, 1'b1, 1'b0, -1);
    for (int k = 0; k < 25; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'h0F) op = 5'h1F;
      run_instr(1, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    run_instr(1, 5'h02, 1'b0, 1'b0, 3);
    reset_pulse(1);
    run_instr(1, 5'h0E, 1'b0, 1'b0, -1);

    @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
